gb_lcd_transmitter: RTL and testbench

- Produces the Game Boy LCD output interface (pixel_data, hsync, vsync, data_latch) from a pixel stream pushed by the PPU.
- It is the transmit end of the link consumed by the video converter's frame capture.
- Buffers incoming pixels in a small FIFO, then serialises them with per-pixel latch strobes, per-line hsync pulses and per-frame vsync pulses.
- All outputs are registered and glitch-free on the single system clock.

---
 rtl/gb_lcd_transmitter.sv | 138 +++++++++++++
 tb/tb_gb_lcd_transmitter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_transmitter.sv
// Game Boy LCD transmitter: a small pixel FIFO feeding a timing FSM that drives
// pixel_data with per-pixel latch strobes, per-line hsync and per-frame vsync.
module gb_lcd_transmitter #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 144,
    parameter int LATCH_HIGH    = 1,
    parameter int LATCH_LOW     = 1,
    parameter int HSYNC_CYCLES  = 4,
    parameter int VSYNC_CYCLES  = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [1:0] pixel_data,
    output logic       hsync,
    output logic       vsync,
    output logic       data_latch,
    output logic       frame_done,
    output logic       underrun,
    output logic       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [7:0]  PX_LAST   = 8'(SCREEN_WIDTH - 1);
    localparam logic [7:0]  LINE_LAST = 8'(SCREEN_HEIGHT - 1);
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_CYCLES - 1);
    localparam logic [15:0] HS_LAST   = 16'(HSYNC_CYCLES - 1);
    localparam logic [15:0] LH_LAST   = 16'(LATCH_HIGH - 1);
    localparam logic [15:0] LL_LAST   = 16'(LATCH_LOW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_FETCH,
        ST_LATCH,
        ST_GAP,
        ST_HSYNC,
        ST_FRAME_END
    } state_t;

    state_t           state, state_next;
    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             fifo_empty, push, pop, leaving;
    logic [15:0]      timer;
    logic [7:0]       px_cnt, line_cnt;

    assign fifo_empty = (level == '0);
    assign pix_ready  = (level != FULL_LEVEL);
    assign push       = pix_valid && pix_ready;
    assign pop        = (state == ST_FETCH) && !fifo_empty;
    assign leaving    = (state_next != state);

    // Storage has no reset; emptiness is defined purely by the pointers and level.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pix_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (enable) state_next = ST_VSYNC;
            ST_VSYNC:     if (timer == VS_LAST) state_next = ST_FETCH;
            ST_FETCH:     if (!fifo_empty) state_next = ST_LATCH;
            ST_LATCH:     if (timer == LH_LAST) state_next = ST_GAP;
            ST_GAP:       if (timer == LL_LAST) state_next = (px_cnt == PX_LAST) ? ST_HSYNC : ST_FETCH;
            ST_HSYNC:     if (timer == HS_LAST) state_next = (line_cnt == LINE_LAST) ? ST_FRAME_END : ST_FETCH;
            ST_FRAME_END: state_next = enable ? ST_VSYNC : ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer      <= '0;
            px_cnt     <= '0;
            line_cnt   <= '0;
            pixel_data <= '0;
            underrun   <= 1'b0;
            vsync      <= 1'b0;
            hsync      <= 1'b0;
            data_latch <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            timer <= leaving ? 16'd0 : timer + 16'd1;
            if (pop) pixel_data <= fifo_mem[rd_ptr];
            if ((state == ST_FETCH) && fifo_empty) underrun <= 1'b1;
            if (state == ST_VSYNC) begin
                px_cnt   <= '0;
                line_cnt <= '0;
            end
            if ((state == ST_GAP) && leaving) begin
                px_cnt <= (px_cnt == PX_LAST) ? 8'd0 : px_cnt + 8'd1;
            end
            if ((state == ST_HSYNC) && leaving) begin
                line_cnt <= line_cnt + 8'd1;
            end
            vsync      <= (state_next == ST_VSYNC);
            hsync      <= (state_next == ST_HSYNC);
            data_latch <= (state_next == ST_LATCH);
            frame_done <= (state_next == ST_FRAME_END);
            busy       <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_gb_lcd_transmitter.sv
// Directed bench for gb_lcd_transmitter with a capture model of the LCD receiver.
// A reduced screen geometry keeps each frame to a few thousand clocks.
module tb_gb_lcd_transmitter;

    localparam int W  = 96;
    localparam int H  = 12;
    localparam int VS = 4;
    localparam int HS = 4;

    logic       clock, reset, enable, pix_valid, pix_ready;
    logic [1:0] pix_data, pixel_data;
    logic       hsync, vsync, data_latch, frame_done, underrun, busy;

    gb_lcd_transmitter #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .LATCH_HIGH(1), .LATCH_LOW(1),
        .HSYNC_CYCLES(HS), .VSYNC_CYCLES(VS), .FIFO_DEPTH(8)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pixel_data(pixel_data),
        .hsync(hsync), .vsync(vsync), .data_latch(data_latch),
        .frame_done(frame_done), .underrun(underrun), .busy(busy)
    );

    int passed = 0;
    int total  = 0;
    int prod_idx = 0;
    int prod_limit = 0;
    int pat_mode = 0;
    bit ready_snap = 1'b0;

    int vs_pulses, hs_pulses, lat_total, fd_pulses, vs_width, hs_width;
    int vs_bad, line_bad, excl_bad, line_lat, cap_line, cap_px;
    logic [1:0] last_pix;
    logic prev_vsync = 1'b0, prev_hsync = 1'b0, prev_latch = 1'b0;
    logic [1:0] cap [W*H];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [1:0] exp_pix(input int idx);
        return 2'((idx + pat_mode * (idx / W)) % 4);
    endfunction

    function automatic int frame_errors(input int base);
        int n = 0;
        for (int i = 0; i < W*H; i++) if (cap[i] !== exp_pix(base + i)) n++;
        return n;
    endfunction

    // Pixel source: a push happened if valid was offered while ready was high before the edge.
    initial begin
        pix_valid = 1'b0;
        pix_data  = 2'b00;
        forever begin
            @(negedge clock);
            if (pix_valid && ready_snap) prod_idx++;
            if (reset) prod_idx = 0;
            pix_valid  = !reset && (prod_idx < prod_limit);
            pix_data   = exp_pix(prod_idx);
            ready_snap = pix_ready;
        end
    end

    // LCD receiver model: counts pulses and rebuilds the frame from latch strobes.
    always @(negedge clock) begin
        if (vsync && !prev_vsync) begin vs_pulses++; vs_width = 0; end
        if (vsync) vs_width++;
        if (!vsync && prev_vsync) begin
            if (vs_width != VS) vs_bad++;
            cap_line = 0; cap_px = 0; line_lat = 0;
        end
        if (data_latch && !prev_latch) begin
            lat_total++; line_lat++; last_pix = pixel_data;
            if (cap_line < H && cap_px < W) cap[cap_line*W + cap_px] = pixel_data;
            cap_px++;
        end
        if (hsync && !prev_hsync) begin hs_pulses++; hs_width = 0; end
        if (hsync) hs_width++;
        if (!hsync && prev_hsync) begin
            if (hs_width != HS || line_lat != W) line_bad++;
            line_lat = 0; cap_line++; cap_px = 0;
        end
        if (frame_done) fd_pulses++;
        if (int'(vsync) + int'(hsync) + int'(data_latch) > 1) excl_bad++;
        prev_vsync = vsync; prev_hsync = hsync; prev_latch = data_latch;
    end

    task automatic clear_stats();
        vs_pulses = 0; hs_pulses = 0; lat_total = 0; fd_pulses = 0; vs_width = 0; hs_width = 0;
        vs_bad = 0; line_bad = 0; excl_bad = 0; line_lat = 0; cap_line = 0; cap_px = 0;
        last_pix = 2'b00;
        foreach (cap[i]) cap[i] = 2'bxx;
    endtask

    task automatic reset_dut();
        reset = 1'b1; enable = 1'b0; prod_limit = 0;
        repeat (3) @(negedge clock);
        clear_stats();
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_frame_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_latches(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (lat_total >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clock);
        total++; if ({pixel_data, hsync, vsync, data_latch, frame_done, underrun, busy} !== 8'h00)
            $display("FAIL reset_outputs: got %b want 00000000", {pixel_data, hsync, vsync, data_latch, frame_done, underrun, busy}); else passed++;
        total++; if (pix_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", pix_ready); else passed++;
        clear_stats();
        reset = 1'b0;
        repeat (5) @(negedge clock);
        total++; if ({busy, vsync} !== 2'b00) $display("FAIL idle_no_enable: busy,vsync got %b want 00", {busy, vsync}); else passed++;
    endtask

    task automatic test_back_pressure();
        int vs_hi = 0;
        int rdy_hi = 0;
        bit ok = 1'b0;
        pat_mode = 0;
        prod_limit = 9;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (prod_idx >= 8) begin ok = 1'b1; break; end
        end
        total++; if (!ok) $display("FAIL bp_fill: pushed %0d want 8", prod_idx); else passed++;
        repeat (3) @(negedge clock);
        total++; if (pix_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", pix_ready); else passed++;
        enable = 1'b1;
        repeat (VS) begin
            @(negedge clock);
            if (vsync === 1'b1) vs_hi++;
            if (pix_ready === 1'b1) rdy_hi++;
        end
        total++; if (vs_hi != VS) $display("FAIL bp_vsync_width: got %0d want %0d", vs_hi, VS); else passed++;
        total++; if (rdy_hi != 0) $display("FAIL bp_ready_in_vsync: ready cycles %0d want 0", rdy_hi); else passed++;
        @(negedge clock);
        total++; if ({vsync, data_latch, pix_ready} !== 3'b000) $display("FAIL bp_fetch_cycle: vs,latch,ready got %b want 000", {vsync, data_latch, pix_ready}); else passed++;
        @(negedge clock);
        total++; if ({data_latch, pix_ready} !== 2'b11) $display("FAIL bp_first_pop: latch,ready got %b want 11", {data_latch, pix_ready}); else passed++;
        total++; if (pixel_data !== exp_pix(0)) $display("FAIL bp_first_pixel: got %0d want %0d", pixel_data, exp_pix(0)); else passed++;
        prod_limit = W*H;
    endtask

    task automatic test_full_frame();
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (hs_pulses >= 5) begin ok = 1'b1; break; end
        end
        total++; if (!ok) $display("FAIL ff_reach_line5: hsyncs %0d want 5", hs_pulses); else passed++;
        enable = 1'b0;
        wait_frame_done(10000, ok);
        total++; if (!ok) $display("FAIL ff_frame_done: got no pulse want 1"); else passed++;
        @(negedge clock);
        total++; if (vs_pulses != 1 || vs_bad != 0) $display("FAIL ff_vsync: pulses %0d bad %0d want 1 0", vs_pulses, vs_bad); else passed++;
        total++; if (hs_pulses != H) $display("FAIL ff_hsync_count: got %0d want %0d", hs_pulses, H); else passed++;
        total++; if (lat_total != W*H) $display("FAIL ff_latch_count: got %0d want %0d", lat_total, W*H); else passed++;
        total++; if (line_bad != 0 || excl_bad != 0) $display("FAIL ff_line_shape: bad lines %0d overlaps %0d want 0 0", line_bad, excl_bad); else passed++;
        total++; if (frame_errors(0) != 0) $display("FAIL ff_pixels: %0d wrong want 0", frame_errors(0)); else passed++;
        total++; if (underrun !== 1'b0) $display("FAIL ff_underrun: got %b want 0", underrun); else passed++;
        repeat (20) @(negedge clock);
        total++; if (busy !== 1'b0 || vs_pulses != 1 || fd_pulses != 1) $display("FAIL ff_enable_drop: busy %b vsyncs %0d frame_dones %0d want 0 1 1", busy, vs_pulses, fd_pulses); else passed++;
    endtask

    task automatic test_underrun();
        int stall_at = 3*W + 50;
        int bad = 0;
        bit ok;
        reset_dut();
        pat_mode = 1;
        prod_limit = stall_at;
        enable = 1'b1;
        repeat (10) @(negedge clock);
        enable = 1'b0;
        total++; if (underrun !== 1'b0) $display("FAIL ur_early: got %b want 0", underrun); else passed++;
        wait_latches(stall_at, 5000, ok);
        total++; if (!ok) $display("FAIL ur_reach_stall: latches %0d want %0d", lat_total, stall_at); else passed++;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (underrun === 1'b1) begin ok = 1'b1; break; end
        end
        total++; if (!ok) $display("FAIL ur_set: got %b want 1", underrun); else passed++;
        repeat (20) begin
            @(negedge clock);
            if (data_latch !== 1'b0 || pixel_data !== exp_pix(stall_at - 1) || underrun !== 1'b1 || lat_total != stall_at) bad++;
        end
        total++; if (bad != 0) $display("FAIL ur_stall_hold: %0d bad cycles want 0", bad); else passed++;
        prod_limit = W*H;
        wait_latches(stall_at + 1, 50, ok);
        total++; if (!ok || last_pix !== exp_pix(stall_at)) $display("FAIL ur_resume: got %0d want %0d", last_pix, exp_pix(stall_at)); else passed++;
        wait_frame_done(10000, ok);
        @(negedge clock);
        total++; if (!ok || lat_total != W*H || frame_errors(0) != 0) $display("FAIL ur_frame: latches %0d wrong %0d want %0d 0", lat_total, frame_errors(0), W*H); else passed++;
        total++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else passed++;
    endtask

    task automatic test_reset_mid_line();
        bit ok;
        reset_dut();
        pat_mode = 1;
        prod_limit = W*H;
        enable = 1'b1;
        wait_latches(10*W + 81, 5000, ok);
        total++; if (!ok) $display("FAIL rm_reach: latches %0d want %0d", lat_total, 10*W + 81); else passed++;
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        total++; if ({pixel_data, hsync, vsync, data_latch, frame_done, underrun, busy, pix_ready} !== 9'b0_0000_0001)
            $display("FAIL rm_outputs: got %b want 000000001", {pixel_data, hsync, vsync, data_latch, frame_done, underrun, busy, pix_ready}); else passed++;
        @(negedge clock);
        clear_stats();
        reset = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        repeat (10) @(negedge clock);
        enable = 1'b0;
        wait_frame_done(10000, ok);
        @(negedge clock);
        total++; if (!ok || vs_pulses != 1 || hs_pulses != H) $display("FAIL rm_restart: vsyncs %0d hsyncs %0d want 1 %0d", vs_pulses, hs_pulses, H); else passed++;
        total++; if (lat_total != W*H || frame_errors(0) != 0) $display("FAIL rm_pixels: latches %0d wrong %0d want %0d 0", lat_total, frame_errors(0), W*H); else passed++;
    endtask

    task automatic test_loopback();
        bit ok;
        reset_dut();
        pat_mode = 2;
        prod_limit = 2*W*H;
        enable = 1'b1;
        wait_frame_done(10000, ok);
        total++; if (!ok || frame_errors(0) != 0) $display("FAIL lb_frame1: done %b wrong %0d want 1 0", ok, frame_errors(0)); else passed++;
        repeat (20) @(negedge clock);
        enable = 1'b0;
        wait_frame_done(10000, ok);
        @(negedge clock);
        total++; if (!ok || frame_errors(W*H) != 0) $display("FAIL lb_frame2: done %b wrong %0d want 1 0", ok, frame_errors(W*H)); else passed++;
        total++; if (vs_pulses != 2 || fd_pulses != 2 || hs_pulses != 2*H) $display("FAIL lb_counts: vsyncs %0d dones %0d hsyncs %0d want 2 2 %0d", vs_pulses, fd_pulses, hs_pulses, 2*H); else passed++;
        total++; if (underrun !== 1'b0 || line_bad != 0 || excl_bad != 0) $display("FAIL lb_clean: underrun %b bad lines %0d overlaps %0d want 0 0 0", underrun, line_bad, excl_bad); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        test_reset();
        test_back_pressure();
        test_full_frame();
        test_underrun();
        test_reset_mid_line();
        test_loopback();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
